// File: rtl/riscv_core_dpath_wb_pipe.sv
// riscv_core_dpath_wb_pipe
//   Writeback pipeline running from M-stage exit to W. It has DEPTH stages.
//   Stage 0 is the youngest entry and stage DEPTH-1 is the W stage.
//   The W stage drives the register-file write port.
//   A late (muldiv) result merges in on the transfer into the W stage.
//   Two decode source ports search the stages, youngest first, for bypass data.
//   Optional feature: define RISCV_WBPIPE_BYPASS_EN to enable data forwarding.
//   Without it, any match only raises byp_stall (interlock-only).
module riscv_core_dpath_wb_pipe #(
  parameter int unsigned W     = 32,
  parameter int unsigned DEPTH = 3
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         stall,
  input  logic         in_val,
  input  logic         in_wen,
  input  logic         in_late,
  input  logic [4:0]   in_waddr,
  input  logic [W-1:0] in_data,
  input  logic [W-1:0] late_data,
  output logic         rf_wen,
  output logic [4:0]   rf_waddr,
  output logic [W-1:0] rf_wdata,
  input  logic [4:0]   byp_raddr0,
  input  logic [4:0]   byp_raddr1,
  output logic         byp_hit0,
  output logic         byp_hit1,
  output logic [W-1:0] byp_data0,
  output logic [W-1:0] byp_data1,
  output logic         byp_stall0,
  output logic         byp_stall1,
  output logic [31:0]  retire_count
);

  localparam int unsigned LAST = DEPTH - 1;

  logic [DEPTH-1:0] val_q,   val_d;
  logic [DEPTH-1:0] wen_q,   wen_d;
  logic [DEPTH-1:0] late_q,  late_d;
  logic [4:0]       waddr_q [DEPTH];
  logic [4:0]       waddr_d [DEPTH];
  logic [W-1:0]     data_q  [DEPTH];
  logic [W-1:0]     data_d  [DEPTH];
  logic [31:0]      retire_q, retire_d;

  logic [4:0]       raddr [2];
  logic             hit   [2];
  logic             stl   [2];
  logic [W-1:0]     bdata [2];

  // Shift the pipe on unstalled cycles and merge the late result into the W stage.
  always_comb begin
    val_d    = val_q;
    wen_d    = wen_q;
    late_d   = late_q;
    waddr_d  = waddr_q;
    data_d   = data_q;
    retire_d = retire_q;
    if (!stall) begin
      val_d[0]   = in_val;
      wen_d[0]   = in_wen;
      late_d[0]  = in_late;
      waddr_d[0] = in_waddr;
      data_d[0]  = in_data;
      for (int unsigned k = 1; k < DEPTH; k++) begin
        val_d[k]   = val_q[k-1];
        wen_d[k]   = wen_q[k-1];
        late_d[k]  = late_q[k-1];
        waddr_d[k] = waddr_q[k-1];
        data_d[k]  = data_q[k-1];
      end
      // late_data is aligned to the entry that is leaving stage LAST-1.
      if (late_q[LAST-1]) begin
        data_d[LAST] = late_data;
      end
      late_d[LAST] = 1'b0;
      if (val_q[LAST]) begin
        retire_d = retire_q + 32'd1;
      end
    end
  end

  // Stage registers and retire counter. Reset clears them asynchronously.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      val_q    <= '0;
      wen_q    <= '0;
      late_q   <= '0;
      retire_q <= '0;
      for (int unsigned k = 0; k < DEPTH; k++) begin
        waddr_q[k] <= '0;
        data_q[k]  <= '0;
      end
    end else begin
      val_q    <= val_d;
      wen_q    <= wen_d;
      late_q   <= late_d;
      retire_q <= retire_d;
      for (int unsigned k = 0; k < DEPTH; k++) begin
        waddr_q[k] <= waddr_d[k];
        data_q[k]  <= data_d[k];
      end
    end
  end

  assign rf_wen       = val_q[LAST] & wen_q[LAST] & (waddr_q[LAST] != 5'd0);
  assign rf_waddr     = waddr_q[LAST];
  assign rf_wdata     = data_q[LAST];
  assign retire_count = retire_q;

  assign raddr[0] = byp_raddr0;
  assign raddr[1] = byp_raddr1;

  // For each bypass port, pick the first matching stage, starting with the youngest.
  always_comb begin
    logic found;
`ifdef RISCV_WBPIPE_BYPASS_EN
    logic         sel_late;
    logic [W-1:0] sel_data;
`endif
    for (int unsigned p = 0; p < 2; p++) begin
      found = 1'b0;
`ifdef RISCV_WBPIPE_BYPASS_EN
      sel_late = 1'b0;
      sel_data = '0;
`endif
      for (int unsigned k = 0; k < DEPTH; k++) begin
        if (!found && val_q[k] && wen_q[k] && (raddr[p] != 5'd0) &&
            (waddr_q[k] == raddr[p])) begin
          found = 1'b1;
`ifdef RISCV_WBPIPE_BYPASS_EN
          sel_late = late_q[k];
          sel_data = data_q[k];
`endif
        end
      end
`ifdef RISCV_WBPIPE_BYPASS_EN
      hit[p]   = found & ~sel_late;
      stl[p]   = found & sel_late;
      bdata[p] = (found && !sel_late) ? sel_data : '0;
`else
      hit[p]   = 1'b0;
      stl[p]   = found;
      bdata[p] = '0;
`endif
    end
  end

  assign byp_hit0   = hit[0];
  assign byp_hit1   = hit[1];
  assign byp_stall0 = stl[0];
  assign byp_stall1 = stl[1];
  assign byp_data0  = bdata[0];
  assign byp_data1  = bdata[1];

endmodule

// File: tb/tb_riscv_core_dpath_wb_pipe.sv
// Testbench for riscv_core_dpath_wb_pipe (DEPTH=3, W=32).
// The reference model keeps the in-flight entries in a queue, youngest first.
// Expectations depend on RISCV_WBPIPE_BYPASS_EN in the same way as the design.
module tb_riscv_core_dpath_wb_pipe;

  localparam int D = 3;

  logic        clk = 1'b0;
  logic        reset_n, stall, in_val, in_wen, in_late;
  logic [4:0]  in_waddr, byp_raddr0, byp_raddr1;
  logic [31:0] in_data, late_data;
  logic        rf_wen, byp_hit0, byp_hit1, byp_stall0, byp_stall1;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata, byp_data0, byp_data1, retire_count;

  int n_checks = 0;
  int n_fail   = 0;

  riscv_core_dpath_wb_pipe #(.W(32), .DEPTH(D)) dut (
    .clk(clk), .reset_n(reset_n), .stall(stall),
    .in_val(in_val), .in_wen(in_wen), .in_late(in_late),
    .in_waddr(in_waddr), .in_data(in_data), .late_data(late_data),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .byp_raddr0(byp_raddr0), .byp_raddr1(byp_raddr1),
    .byp_hit0(byp_hit0), .byp_hit1(byp_hit1),
    .byp_data0(byp_data0), .byp_data1(byp_data1),
    .byp_stall0(byp_stall0), .byp_stall1(byp_stall1),
    .retire_count(retire_count)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct {
    bit        val;
    bit        wen;
    bit        late;
    bit [4:0]  a;
    bit [31:0] d;
  } ent_t;

  ent_t    pipe[$];   // index 0 = youngest, D-1 = writeback
  bit [31:0] m_ret;

  task automatic model_reset();
    ent_t z;
    z = '{0, 0, 0, 5'd0, 32'd0};
    pipe = {};
    for (int i = 0; i < D; i++) pipe.push_back(z);
    m_ret = 0;
  endtask

  task automatic model_clock();
    ent_t n, mv;
    if (stall) return;
    if (pipe[D-1].val) m_ret = m_ret + 1;
    mv = pipe[D-2];
    if (mv.late) begin
      mv.d    = late_data;
      mv.late = 0;
    end
    pipe[D-2] = mv;
    n = '{in_val, in_wen, in_late, in_waddr, in_data};
    pipe.push_front(n);
    void'(pipe.pop_back());
  endtask

  function automatic void mbyp(input bit [4:0] ra, output bit h, output bit s, output bit [31:0] dd);
    h = 0; s = 0; dd = 0;
    for (int i = 0; i < D; i++) begin
      if (ra != 0 && pipe[i].val && pipe[i].wen && pipe[i].a == ra) begin
`ifdef RISCV_WBPIPE_BYPASS_EN
        if (pipe[i].late) s = 1;
        else begin h = 1; dd = pipe[i].d; end
`else
        s = 1;
`endif
        break;
      end
    end
  endfunction

  function automatic logic [137:0] model_out();
    bit h0, s0, h1, s1;
    bit [31:0] d0, d1;
    bit w;
    mbyp(byp_raddr0, h0, s0, d0);
    mbyp(byp_raddr1, h1, s1, d1);
    w = pipe[D-1].val && pipe[D-1].wen && (pipe[D-1].a != 0);
    return {w, pipe[D-1].a, pipe[D-1].d, h0, s0, d0, h1, s1, d1, m_ret};
  endfunction

  // Advance one clock edge. Inputs change 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    if (reset_n) model_clock();
    #1;
  endtask

  task automatic idle_inputs();
    stall = 0; in_val = 0; in_wen = 0; in_late = 0;
    in_waddr = 0; in_data = 0; late_data = 32'h5555_5555;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_n = 0; idle_inputs(); byp_raddr0 = 0; byp_raddr1 = 0;
    model_reset();
    #12;
    n_checks++;
    if ({rf_wen, rf_waddr, rf_wdata, retire_count} !== 70'd0) begin
      n_fail++; $display("FAIL reset_rf got=%h want=0", {rf_wen, rf_waddr, rf_wdata, retire_count});
    end
    n_checks++;
    if ({byp_hit0, byp_hit1, byp_stall0, byp_stall1, byp_data0, byp_data1} !== 68'd0) begin
      n_fail++; $display("FAIL reset_byp got=%h want=0", {byp_hit0, byp_hit1, byp_stall0, byp_stall1, byp_data0, byp_data1});
    end
    @(negedge clk); reset_n = 1;
    tick();
    n_checks++;
    if ({rf_wen, retire_count, byp_hit0, byp_stall0} !== 35'd0) begin
      n_fail++; $display("FAIL post_reset got=%h want=0", {rf_wen, retire_count, byp_hit0, byp_stall0});
    end
  endtask

  task automatic test_basic();
    bit [31:0] r0;
    r0 = m_ret;
    in_val = 1; in_wen = 1; in_waddr = 5; in_data = 32'h1234; byp_raddr0 = 5;
    tick();
    idle_inputs();
    tick();
    n_checks++;
    if (rf_wen !== 1'b0) begin n_fail++; $display("FAIL basic_early_wen got=%b want=0", rf_wen); end
    tick();
    n_checks++;
    if ({rf_wen, rf_waddr, rf_wdata} !== {1'b1, 5'd5, 32'h1234}) begin
      n_fail++; $display("FAIL basic_write got=%h want=%h", {rf_wen, rf_waddr, rf_wdata}, {1'b1, 5'd5, 32'h1234});
    end
    n_checks++;
`ifdef RISCV_WBPIPE_BYPASS_EN
    if ({byp_hit0, byp_stall0, byp_data0} !== {1'b1, 1'b0, 32'h1234}) begin
`else
    if ({byp_hit0, byp_stall0, byp_data0} !== {1'b0, 1'b1, 32'h0}) begin
`endif
      n_fail++; $display("FAIL basic_byp got=%h", {byp_hit0, byp_stall0, byp_data0});
    end
    tick();
    n_checks++;
    if (retire_count !== r0 + 1 || rf_wen !== 1'b0) begin
      n_fail++; $display("FAIL basic_retire got=%0d wen=%b want=%0d wen=0", retire_count, rf_wen, r0 + 1);
    end
  endtask

  task automatic test_late();
    in_val = 1; in_wen = 1; in_late = 1; in_waddr = 7; in_data = 32'hDEAD; byp_raddr0 = 7;
    tick();
    idle_inputs();
    for (int s = 0; s < 2; s++) begin
      n_checks++;
      if ({byp_hit0, byp_stall0, byp_data0} !== {1'b0, 1'b1, 32'h0}) begin
        n_fail++; $display("FAIL late_stall_s%0d got=%h want=%h", s, {byp_hit0, byp_stall0, byp_data0}, {1'b0, 1'b1, 32'h0});
      end
      if (s == 0) tick();
    end
    late_data = 32'hCAFE;
    tick();
    late_data = 32'h0BAD_0BAD;
    #1;
    n_checks++;
    if ({rf_wen, rf_waddr, rf_wdata} !== {1'b1, 5'd7, 32'hCAFE}) begin
      n_fail++; $display("FAIL late_write got=%h want=%h", {rf_wen, rf_waddr, rf_wdata}, {1'b1, 5'd7, 32'hCAFE});
    end
    n_checks++;
`ifdef RISCV_WBPIPE_BYPASS_EN
    if ({byp_hit0, byp_stall0, byp_data0} !== {1'b1, 1'b0, 32'hCAFE}) begin
`else
    if ({byp_hit0, byp_stall0, byp_data0} !== {1'b0, 1'b1, 32'h0}) begin
`endif
      n_fail++; $display("FAIL late_byp_w got=%h", {byp_hit0, byp_stall0, byp_data0});
    end
    tick();
  endtask

  task automatic test_youngest();
    in_val = 1; in_wen = 1; in_waddr = 3; in_data = 32'hA; byp_raddr1 = 3;
    tick();
    in_data = 32'hB;
    tick();
    idle_inputs();
    for (int s = 0; s < 2; s++) begin
      #1;
      n_checks++;
`ifdef RISCV_WBPIPE_BYPASS_EN
      if ({byp_hit1, byp_stall1, byp_data1} !== {1'b1, 1'b0, 32'hB}) begin
`else
      if ({byp_hit1, byp_stall1, byp_data1} !== {1'b0, 1'b1, 32'h0}) begin
`endif
        n_fail++; $display("FAIL youngest_s%0d got=%h", s, {byp_hit1, byp_stall1, byp_data1});
      end
      tick();
    end
    tick(); tick();
  endtask

  task automatic test_stall();
    bit [31:0] r0;
    in_val = 1; in_wen = 1; in_waddr = 12; in_data = 32'h77;
    tick();
    idle_inputs();
    tick(); tick();
    r0 = m_ret;
    stall = 1; in_val = 1; in_wen = 1; in_waddr = 4; in_data = 32'h99; byp_raddr0 = 4;
    for (int c = 0; c < 4; c++) begin
      tick();
      n_checks++;
      if ({rf_wen, rf_waddr, rf_wdata, retire_count} !== {1'b1, 5'd12, 32'h77, r0}) begin
        n_fail++; $display("FAIL stall_hold_c%0d got=%h want=%h", c, {rf_wen, rf_waddr, rf_wdata, retire_count}, {1'b1, 5'd12, 32'h77, r0});
      end
    end
    n_checks++;
    if ({byp_hit0, byp_stall0} !== 2'b00) begin
      n_fail++; $display("FAIL stall_ignore_in got=%b want=00", {byp_hit0, byp_stall0});
    end
    idle_inputs();
    tick();
    n_checks++;
    if (retire_count !== r0 + 1 || rf_wen !== 1'b0) begin
      n_fail++; $display("FAIL stall_release got=%0d wen=%b want=%0d wen=0", retire_count, rf_wen, r0 + 1);
    end
  endtask

  task automatic test_interlock();
    in_val = 1; in_wen = 1; in_waddr = 9; in_data = 32'h9999; byp_raddr0 = 9;
    tick();
    idle_inputs();
    n_checks++;
`ifdef RISCV_WBPIPE_BYPASS_EN
    if ({byp_hit0, byp_stall0, byp_data0} !== {1'b1, 1'b0, 32'h9999}) begin
`else
    if ({byp_hit0, byp_stall0, byp_data0} !== {1'b0, 1'b1, 32'h0}) begin
`endif
      n_fail++; $display("FAIL interlock got=%h", {byp_hit0, byp_stall0, byp_data0});
    end
    tick(); tick(); tick();
  endtask

  task automatic test_reset_mid();
    in_val = 1; in_wen = 1; in_waddr = 1; in_data = 32'h11;
    tick();
    in_waddr = 0; in_data = 32'h22;
    tick();
    in_waddr = 2; in_data = 32'h33;
    tick();
    idle_inputs();
    byp_raddr0 = 0; byp_raddr1 = 0;
    #1;
    n_checks++;
    if ({rf_wen, byp_hit0, byp_stall0} !== 3'b100) begin
      n_fail++; $display("FAIL mid_pre got=%b want=100", {rf_wen, byp_hit0, byp_stall0});
    end
    byp_raddr0 = 2; byp_raddr1 = 1;
    #1;
    reset_n = 0;
    model_reset();
    #1;
    n_checks++;
    if ({rf_wen, rf_waddr, rf_wdata, retire_count, byp_hit0, byp_hit1, byp_stall0, byp_stall1, byp_data0, byp_data1} !== 138'd0) begin
      n_fail++; $display("FAIL mid_reset got=%h want=0", {rf_wen, rf_waddr, rf_wdata, retire_count, byp_hit0, byp_hit1, byp_stall0, byp_stall1, byp_data0, byp_data1});
    end
    @(negedge clk); reset_n = 1;
    tick();
    // a waddr=0 entry flows all the way through without writing or matching
    in_val = 1; in_wen = 1; in_waddr = 0; in_data = 32'h44; byp_raddr0 = 0;
    tick();
    idle_inputs();
    for (int c = 0; c < 3; c++) begin
      n_checks++;
      if ({rf_wen, byp_hit0, byp_stall0} !== 3'b000) begin
        n_fail++; $display("FAIL zero_addr_c%0d got=%b want=000", c, {rf_wen, byp_hit0, byp_stall0});
      end
      tick();
    end
  endtask

  task automatic test_random();
    logic [137:0] got, want;
    for (int c = 0; c < 400; c++) begin
      stall      = ($urandom_range(0, 3) == 0);
      in_val     = $urandom_range(0, 1);
      in_wen     = ($urandom_range(0, 3) != 0);
      in_late    = ($urandom_range(0, 3) == 0);
      in_waddr   = 5'($urandom_range(0, 7));
      in_data    = $urandom;
      late_data  = $urandom;
      byp_raddr0 = 5'($urandom_range(0, 7));
      byp_raddr1 = 5'($urandom_range(0, 7));
      #1;
      want = model_out();
      got  = {rf_wen, rf_waddr, rf_wdata, byp_hit0, byp_stall0, byp_data0,
              byp_hit1, byp_stall1, byp_data1, retire_count};
      n_checks++;
      if (got !== want) begin
        n_fail++; $display("FAIL random_c%0d got=%h want=%h", c, got, want);
      end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_late();
    test_youngest();
    test_stall();
    test_interlock();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
